// File: rtl/bus_intr_arb_pkg.sv
// Shared definitions for the iopage interrupt arbiter.
// Contents: requester count, field widths, minimum usable bus-request level,
// FSM state encoding and a one-hot helper.
package bus_intr_arb_pkg;

    localparam int NREQ  = 4;
    localparam int BR_W  = 3;
    localparam int VEC_W = 8;
    localparam int IDX_W = 2;

    // Bus-request levels below this can never interrupt the CPU.
    localparam logic [BR_W-1:0] BR_MIN = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_GRANT = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_e;

    function automatic logic [NREQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/bus_intr_arb_if.sv
// Device/CPU interrupt signalling bundle for bus_intr_arb.
//   dev_irq     per-device request level
//   dev_br      per-device bus-request priority, 3 bits each
//   dev_vec     per-device vector, 8 bits each
//   cpu_ipl     current processor priority
//   cpu_int_ack CPU accepts the presented interrupt (pulse)
//   cpu_int_req interrupt pending toward the CPU
//   cpu_int_vec vector of the pending interrupt
//   dev_ack     one-hot acknowledge pulse to the granted device
// modport slave is the arbiter side, modport master the device/CPU side.
interface bus_intr_arb_if;
    import bus_intr_arb_pkg::*;

    logic [NREQ-1:0]       dev_irq;
    logic [NREQ*BR_W-1:0]  dev_br;
    logic [NREQ*VEC_W-1:0] dev_vec;
    logic [BR_W-1:0]       cpu_ipl;
    logic                  cpu_int_ack;
    logic                  cpu_int_req;
    logic [VEC_W-1:0]      cpu_int_vec;
    logic [NREQ-1:0]       dev_ack;

    modport master (
        output dev_irq, dev_br, dev_vec, cpu_ipl, cpu_int_ack,
        input  cpu_int_req, cpu_int_vec, dev_ack
    );

    modport slave (
        input  dev_irq, dev_br, dev_vec, cpu_ipl, cpu_int_ack,
        output cpu_int_req, cpu_int_vec, dev_ack
    );

endinterface

// File: rtl/bus_intr_arb_prio_pick.sv
// intr_prio_pick: combinational winner selection.
// A device is a candidate when it requests, its level is at least BR_MIN and
// its level is above cpu_ipl. The highest level wins; equal levels resolve to
// the first candidate found scanning upward from rr_ptr with wrap.
//   dev_irq, dev_br, cpu_ipl, rr_ptr  inputs
//   win_valid                         some device is eligible
//   win_idx                           index of the winner (0 when none)
module intr_prio_pick
    import bus_intr_arb_pkg::*;
(
    input  logic [NREQ-1:0]      dev_irq,
    input  logic [NREQ*BR_W-1:0] dev_br,
    input  logic [BR_W-1:0]      cpu_ipl,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic                 win_valid,
    output logic [IDX_W-1:0]     win_idx
);

    logic [BR_W-1:0]  best_br;
    logic [IDX_W-1:0] cand;
    logic [BR_W-1:0]  cand_br;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        best_br   = '0;
        cand      = '0;
        cand_br   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // IDX_W-bit add gives the 3->0 wrap for free.
            cand    = rr_ptr + IDX_W'(k);
            cand_br = dev_br[BR_W*int'(cand) +: BR_W];
            // Strict '>' keeps the earliest round-robin candidate on a tie.
            if (dev_irq[cand] && (cand_br >= BR_MIN) && (cand_br > cpu_ipl) &&
                (!win_valid || (cand_br > best_br))) begin
                win_valid = 1'b1;
                win_idx   = cand;
                best_br   = cand_br;
            end
        end
    end

endmodule

// File: rtl/bus_intr_arb.sv
// bus_intr_arb: iopage device interrupt arbiter.
// Picks one eligible device, presents its vector to the CPU until the CPU
// acknowledges or the request becomes ineligible, then pulses dev_ack to the
// granted device and leaves one dead cycle for it to drop its request.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      bus_intr_arb_if.slave (device requests, CPU handshake, acks)
//
// state    | meaning
// ST_IDLE  | arbitrating; takes a winner as soon as one is eligible
// ST_PEND  | winner latched, cpu_int_req high, waiting for cpu_int_ack
// ST_GRANT | single cycle, dev_ack to the winner, round-robin pointer moves
// ST_HOLD  | dead cycle so the device can clear its request
module bus_intr_arb
    import bus_intr_arb_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    bus_intr_arb_if.slave  bus
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BR_W-1:0]  br_q, br_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             int_req_q, int_req_d;
    logic [VEC_W-1:0] int_vec_q, int_vec_d;
    logic [NREQ-1:0]  dev_ack_q, dev_ack_d;

    logic             win_valid;
    logic [IDX_W-1:0] win_idx;

    intr_prio_pick u_pick (
        .dev_irq   (bus.dev_irq),
        .dev_br    (bus.dev_br),
        .cpu_ipl   (bus.cpu_ipl),
        .rr_ptr    (rr_ptr_q),
        .win_valid (win_valid),
        .win_idx   (win_idx)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        br_d     = br_q;
        vec_d    = vec_q;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    idx_d   = win_idx;
                    br_d    = bus.dev_br[BR_W*int'(win_idx) +: BR_W];
                    vec_d   = bus.dev_vec[VEC_W*int'(win_idx) +: VEC_W];
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // Ack takes precedence over a withdraw seen in the same cycle.
                if (bus.cpu_int_ack) begin
                    state_d = ST_GRANT;
                end else if (!bus.dev_irq[idx_q] || (bus.cpu_ipl >= br_q)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                rr_ptr_d = idx_q + IDX_W'(1);
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered versions of what the next state implies,
        // so they line up with the state they describe.
        int_req_d = (state_d == ST_PEND);
        int_vec_d = int_req_d ? vec_d : '0;
        dev_ack_d = (state_d == ST_GRANT) ? idx_onehot(idx_d) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            idx_q     <= '0;
            br_q      <= '0;
            vec_q     <= '0;
            int_req_q <= 1'b0;
            int_vec_q <= '0;
            dev_ack_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            idx_q     <= idx_d;
            br_q      <= br_d;
            vec_q     <= vec_d;
            int_req_q <= int_req_d;
            int_vec_q <= int_vec_d;
            dev_ack_q <= dev_ack_d;
        end
    end

    assign bus.cpu_int_req = int_req_q;
    assign bus.cpu_int_vec = int_vec_q;
    assign bus.dev_ack     = dev_ack_q;

endmodule

// File: tb/tb_bus_intr_arb.sv
// Directed bench for bus_intr_arb with a transaction-level reference model
// checked against the outputs on every falling edge.
module tb_bus_intr_arb;
    import bus_intr_arb_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_err    = 0;

    bus_intr_arb_if bus ();

    bus_intr_arb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending flag, a count of edges during which no new
    // arbitration may happen, and a priority-level scan for the winner.
    logic       m_req;
    logic [7:0] m_vec;
    logic [3:0] m_ack;
    int         m_gap, m_idx, m_br, m_rr;
    logic       m_found;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_req = 0; m_vec = 0; m_ack = 0;
            m_gap = 0; m_idx = 0; m_br = 0; m_rr = 0;
        end else if (m_gap > 0) begin
            m_gap--;
            m_ack = 0;
        end else if (m_req) begin
            if (bus.cpu_int_ack) begin
                m_req = 0; m_vec = 0;
                m_ack = 4'b0001 << m_idx;
                m_rr  = (m_idx + 1) % 4;
                m_gap = 2;
            end else if (!bus.dev_irq[m_idx] || int'(bus.cpu_ipl) >= m_br) begin
                m_req = 0; m_vec = 0;
            end
        end else begin
            m_found = 0;
            for (int lvl = 7; lvl >= 4; lvl--) begin
                for (int k = 0; k < 4; k++) begin
                    int d;
                    d = (m_rr + k) % 4;
                    if (!m_found && lvl > int'(bus.cpu_ipl) && bus.dev_irq[d] &&
                        int'(bus.dev_br[3*d +: 3]) == lvl) begin
                        m_found = 1;
                        m_idx   = d;
                        m_br    = lvl;
                        m_vec   = bus.dev_vec[8*d +: 8];
                        m_req   = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("model_req", {31'd0, bus.cpu_int_req}, {31'd0, m_req});
            chk("model_vec", {24'd0, bus.cpu_int_vec}, {24'd0, m_vec});
            chk("model_ack", {28'd0, bus.dev_ack},     {28'd0, m_ack});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_dev(input int i, input logic [2:0] br, input logic [7:0] vec);
        bus.dev_br[3*i +: 3]  = br;
        bus.dev_vec[8*i +: 8] = vec;
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (bus.cpu_int_req !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk({nm, "_req_seen"}, {31'd0, bus.cpu_int_req}, 32'd1);
    endtask

    task automatic pulse_ack();
        bus.cpu_int_ack = 1'b1;
        tick(1);
        bus.cpu_int_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset_n         = 1'b0;
        bus.dev_irq     = '0;
        bus.dev_br      = '0;
        bus.dev_vec     = '0;
        bus.cpu_ipl     = '0;
        bus.cpu_int_ack = 1'b0;
        tick(2);
        chk("rst_req", {31'd0, bus.cpu_int_req}, 32'd0);
        chk("rst_vec", {24'd0, bus.cpu_int_vec}, 32'd0);
        chk("rst_ack", {28'd0, bus.dev_ack},     32'd0);
        reset_n = 1'b1;
        tick(1);

        // Single request: presented one cycle after it becomes eligible.
        set_dev(0, 3'd6, 8'o100);
        bus.dev_irq = 4'b0001;
        tick(1);
        chk("single_req", {31'd0, bus.cpu_int_req}, 32'd1);
        chk("single_vec", {24'd0, bus.cpu_int_vec}, 32'o100);
        pulse_ack();
        chk("single_ack", {28'd0, bus.dev_ack}, 32'b0001);
        chk("single_req_off", {31'd0, bus.cpu_int_req}, 32'd0);
        bus.dev_irq = 4'b0000;
        tick(1);
        chk("single_ack_once", {28'd0, bus.dev_ack}, 32'd0);
        tick(3);

        // Priority: higher level wins, lower presented after it clears.
        set_dev(0, 3'd4, 8'h10);
        set_dev(1, 3'd6, 8'h21);
        bus.dev_irq = 4'b0011;
        wait_req("prio1");
        chk("prio_vec1", {24'd0, bus.cpu_int_vec}, 32'h21);
        pulse_ack();
        chk("prio_ack1", {28'd0, bus.dev_ack}, 32'b0010);
        bus.dev_irq = 4'b0001;
        tick(1);
        chk("prio_hold_req", {31'd0, bus.cpu_int_req}, 32'd0);
        tick(1);
        chk("prio_idle_req", {31'd0, bus.cpu_int_req}, 32'd0);
        tick(1);
        chk("prio_req2", {31'd0, bus.cpu_int_req}, 32'd1);
        chk("prio_vec2", {24'd0, bus.cpu_int_vec}, 32'h10);
        pulse_ack();
        chk("prio_ack2", {28'd0, bus.dev_ack}, 32'b0001);
        bus.dev_irq = 4'b0000;
        tick(4);

        // Round robin among equal levels, requests held throughout.
        do_reset();
        for (int i = 0; i < 4; i++) set_dev(i, 3'd5, 8'h40 + 8'(i));
        bus.dev_irq = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            logic [3:0] exp_ack;
            exp_ack = 4'b0001 << (g % 4);
            wait_req("rr");
            chk("rr_vec", {24'd0, bus.cpu_int_vec}, 32'h40 + (g % 4));
            pulse_ack();
            chk("rr_ack", {28'd0, bus.dev_ack}, {28'd0, exp_ack});
        end
        bus.dev_irq = 4'b0000;
        tick(4);

        // Masking by cpu_ipl withdraws the request; lowering re-presents it.
        set_dev(0, 3'd5, 8'h33);
        bus.dev_irq = 4'b0001;
        wait_req("mask");
        bus.cpu_ipl = 3'd5;
        tick(1);
        chk("mask_drop", {31'd0, bus.cpu_int_req}, 32'd0);
        chk("mask_vec0", {24'd0, bus.cpu_int_vec}, 32'd0);
        tick(3);
        chk("mask_stay", {31'd0, bus.cpu_int_req}, 32'd0);
        bus.cpu_ipl = 3'd4;
        wait_req("unmask");
        chk("unmask_vec", {24'd0, bus.cpu_int_vec}, 32'h33);
        pulse_ack();
        chk("unmask_ack", {28'd0, bus.dev_ack}, 32'b0001);
        bus.dev_irq = 4'b0000;
        bus.cpu_ipl = 3'd0;
        tick(4);

        // Ack in the same cycle the device drops its request: ack wins.
        set_dev(2, 3'd6, 8'h77);
        bus.dev_irq = 4'b0100;
        wait_req("simul");
        chk("simul_vec", {24'd0, bus.cpu_int_vec}, 32'h77);
        bus.dev_irq = 4'b0000;
        pulse_ack();
        chk("simul_ack", {28'd0, bus.dev_ack}, 32'b0100);
        tick(4);

        // Reset while pending, with an ack already on its way.
        set_dev(1, 3'd7, 8'h55);
        bus.dev_irq = 4'b0010;
        wait_req("rstp");
        bus.cpu_int_ack = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstp_req", {31'd0, bus.cpu_int_req}, 32'd0);
        chk("rstp_vec", {24'd0, bus.cpu_int_vec}, 32'd0);
        chk("rstp_ack", {28'd0, bus.dev_ack},     32'd0);
        tick(1);
        bus.cpu_int_ack = 1'b0;
        bus.dev_irq     = 4'b0000;
        reset_n         = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            if (bus.dev_ack !== 4'b0000) seen++;
        end
        chk("rstp_no_ack", seen, 0);

        // Levels below 4 never interrupt; level not above ipl is masked;
        // a stray ack while idle does nothing.
        set_dev(0, 3'd3, 8'h99);
        bus.dev_irq = 4'b0001;
        tick(4);
        chk("br_low_req", {31'd0, bus.cpu_int_req}, 32'd0);
        set_dev(0, 3'd7, 8'h99);
        bus.cpu_ipl = 3'd7;
        tick(3);
        chk("ipl7_req", {31'd0, bus.cpu_int_req}, 32'd0);
        pulse_ack();
        chk("stray_ack", {28'd0, bus.dev_ack}, 32'd0);
        bus.cpu_ipl = 3'd6;
        wait_req("ipl6");
        chk("ipl6_vec", {24'd0, bus.cpu_int_vec}, 32'h99);
        pulse_ack();
        chk("ipl6_ack", {28'd0, bus.dev_ack}, 32'b0001);
        bus.dev_irq = 4'b0000;
        tick(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_intr_arb.md
BUS_INTR_ARB -- requirements
Module: bus_intr_arb

Interface
REQ-001 Parameter: NREQ, 4, number of iopage device interrupt requesters (fixed at 4 in this revision).
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 dev_irq  input  4  per-device interrupt request level (device "interrupt" outputs), bit i = device i.
REQ-005 dev_br  input  12  per-device bus-request priority, 3 bits per device, device i at [3i+2:3i]; valid values 4..7.
REQ-006 dev_vec  input  32  per-device vector, 8 bits per device, device i at [8i+7:8i].
REQ-007 cpu_ipl  input  3  current processor priority from PSW[7:5].
REQ-008 cpu_int_ack  input  1  CPU accepts the presented interrupt; single-cycle pulse.
REQ-009 cpu_int_req  output  1  interrupt pending toward CPU.
REQ-010 cpu_int_vec  output  8  vector of the pending interrupt.
REQ-011 dev_ack  output  4  one-hot, single-cycle acknowledge to the granted device ("interrupt_ack").

Function
REQ-012 Eligibility: device i eligible when dev_irq[i]=1 and dev_br[i] > cpu_ipl (unsigned compare).
REQ-013 Winner: eligible device with the highest dev_br; ties broken round-robin starting at rr_ptr, searching upward with wrap 3->0.
REQ-014 FSM states: IDLE, PEND, GRANT, HOLD; encoding held in the shared package.
REQ-015 IDLE: when at least one device is eligible, latch winner index, its dev_br and dev_vec; go to PEND next cycle; cpu_int_req=0 in IDLE.
REQ-016 PEND: cpu_int_req=1, cpu_int_vec = latched vector; latched values do not change while in PEND (no preemption by later higher-priority requests).
REQ-017 PEND withdraw: if latched device drops dev_irq, or cpu_ipl >= latched br, and cpu_int_ack=0 in the same cycle -> IDLE next cycle, cpu_int_req=0 from that cycle.
REQ-018 PEND with cpu_int_ack=1 -> GRANT regardless of simultaneous withdraw conditions (ack wins).
REQ-019 GRANT: lasts exactly one cycle; dev_ack[winner]=1, all other dev_ack bits 0; cpu_int_req=0; rr_ptr <= winner+1 mod 4.
REQ-020 HOLD: one dead cycle, no arbitration, cpu_int_req=0, so the device can clear its request; then IDLE.
REQ-021 cpu_int_ack outside PEND is ignored; dev_ack never asserted outside GRANT.
REQ-022 Minimum latency: request eligible in cycle N -> cpu_int_req high in cycle N+1; ack in cycle M -> dev_ack pulse in cycle M+1; next arbitration no earlier than cycle M+3.
REQ-023 cpu_int_vec = 0 whenever cpu_int_req = 0.
REQ-024 dev_br values below 4 are treated as never eligible.

Reset
REQ-025 reset_n low asynchronously forces: state IDLE, rr_ptr 0, latched index/br/vec 0, cpu_int_req 0, cpu_int_vec 0, dev_ack 0.
REQ-026 Reset asserted mid-PEND or mid-GRANT aborts the transaction; no dev_ack pulse is emitted after reset release for it.
REQ-027 First arbitration possible on the first posedge clk after reset_n deasserts.

Structure
REQ-028 Shared package holds: FSM state encoding, NREQ, BR width (3), vector width (8), minimum BR constant (4).
REQ-029 One combinational sub-module, intr_prio_pick, computes winner index and valid from dev_irq, dev_br, cpu_ipl, rr_ptr; FSM and latches stay in bus_intr_arb.
REQ-030 All outputs driven from registers.

Verification
REQ-031 Single request: dev_irq=0001, br0=6, vec0=8'o100, ipl=0 -> int_req next cycle, vec 8'o100; ack -> dev_ack=0001 one cycle later for exactly one cycle.
REQ-032 Priority: dev_irq=0011, br0=4, br1=6 -> vec1 presented; after grant/HOLD with dev1 cleared, vec0 presented.
REQ-033 Round-robin: dev_irq=1111, all br=5, devices held asserted -> grant order 0,1,2,3,0.
REQ-034 Masking/withdraw: br0=5 pending, raise cpu_ipl to 5 before ack -> int_req drops next cycle, no dev_ack; lower ipl to 4 -> re-presented.
REQ-035 Simultaneous: in PEND, device drops dev_irq in same cycle as cpu_int_ack -> GRANT still occurs, dev_ack pulses.
REQ-036 Reset mid-PEND: assert reset_n low while int_req=1 -> int_req, vec, dev_ack 0 immediately (asynchronously, before next posedge); no dev_ack after release.
